// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole scheduler.
package mole_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_UP    = 3'd2,
        ST_GAP   = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int         NUM_MOLES = 18;
    // Fibonacci taps for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'h01;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit LFSR and mapping of its low bits to a mole position
// that never repeats the previous one.
module mole_lfsr
    import mole_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] prev_pos,
    output logic [4:0] pos_next
);

    localparam logic [4:0] MOLES = 5'(NUM_MOLES);
    localparam logic [4:0] LAST  = 5'(NUM_MOLES - 1);

    logic [7:0] lfsr;
    logic [4:0] wrapped;

    // LFSR advances every cycle, independent of game state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    // fold 0..31 into 0..17, then step past the previous position
    always_comb begin
        wrapped = (lfsr[4:0] >= MOLES) ? lfsr[4:0] - MOLES : lfsr[4:0];
        if (wrapped == prev_pos) begin
            pos_next = (wrapped == LAST) ? 5'd0 : wrapped + 5'd1;
        end else begin
            pos_next = wrapped;
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Game sequencer: lights one of 18 moles at a time, scores hits, counts down
// game time. Define MOLE_SPEEDUP_EN to shorten the up time every 8th hit.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int TICK_DIV   = 2_500_000,
    parameter int UP_TICKS   = 20,
    parameter int GAP_TICKS  = 4,
    parameter int GAME_TICKS = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hit,
    output logic [17:0] ledr,
    output logic [7:0]  score,
    output logic [7:0]  time_left,
    output logic        game_over
);

    localparam int               PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]       UP_INIT    = 8'(UP_TICKS);
    localparam logic [7:0]       GAP_INIT   = 8'(GAP_TICKS);
    localparam logic [7:0]       GAME_INIT  = 8'(GAME_TICKS);

    state_t        state;
    logic [PW-1:0] presc;
    logic [7:0]    up_cnt;
    logic [7:0]    gap_cnt;
    logic [7:0]    up_reload;
    logic [4:0]    pos;
    logic [4:0]    pos_next;
    logic          tick;
    logic          in_game;
    logic          new_game;
    logic          game_end;

    assign tick     = (presc == PRESC_LAST);
    assign in_game  = (state == ST_SPAWN) || (state == ST_UP) || (state == ST_GAP);
    assign new_game = ((state == ST_IDLE) || (state == ST_OVER)) && start;
    assign game_end = in_game && tick && (time_left == 8'd1);

    mole_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .prev_pos (pos),
        .pos_next (pos_next)
    );

    // tick prescaler, realigned at the start of every game
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (new_game || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

`ifdef MOLE_SPEEDUP_EN
    logic [7:0] up_time;

    // every 8th scored hit trims one tick off the mole up time, floor 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_time <= UP_INIT;
        end else if (new_game) begin
            up_time <= UP_INIT;
        end else if ((state == ST_UP) && hit && (score[2:0] == 3'd7) &&
                     (score != 8'hFF) && (up_time > 8'd2)) begin
            up_time <= up_time - 8'd1;
        end else begin
            up_time <= up_time;
        end
    end

    assign up_reload = up_time;
`else
    assign up_reload = UP_INIT;
`endif

    // game FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ledr      <= 18'd0;
            score     <= 8'd0;
            time_left <= 8'd0;
            game_over <= 1'b0;
            up_cnt    <= 8'd0;
            gap_cnt   <= 8'd0;
            pos       <= 5'd31;
        end else if (game_end) begin
            // a hit on the final tick still counts
            if ((state == ST_UP) && hit) begin
                score <= sat_inc(score);
            end else begin
                score <= score;
            end
            time_left <= 8'd0;
            ledr      <= 18'd0;
            game_over <= 1'b1;
            state     <= ST_OVER;
        end else begin
            if (in_game && tick) begin
                time_left <= time_left - 8'd1;
            end else begin
                time_left <= time_left;
            end
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        score     <= 8'd0;
                        time_left <= GAME_INIT;
                        game_over <= 1'b0;
                        ledr      <= 18'd0;
                        state     <= ST_SPAWN;
                    end else begin
                        state <= state;
                    end
                end
                ST_SPAWN: begin
                    pos    <= pos_next;
                    ledr   <= 18'd1 << pos_next;
                    up_cnt <= up_reload;
                    state  <= ST_UP;
                end
                ST_UP: begin
                    if (hit) begin
                        score   <= sat_inc(score);
                        ledr    <= 18'd0;
                        gap_cnt <= GAP_INIT;
                        state   <= ST_GAP;
                    end else if (tick && (up_cnt <= 8'd1)) begin
                        ledr    <= 18'd0;
                        gap_cnt <= GAP_INIT;
                        state   <= ST_GAP;
                    end else if (tick) begin
                        up_cnt <= up_cnt - 8'd1;
                    end else begin
                        up_cnt <= up_cnt;
                    end
                end
                ST_GAP: begin
                    if (tick && (gap_cnt <= 8'd1)) begin
                        state <= ST_SPAWN;
                    end else if (tick) begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end else begin
                        gap_cnt <= gap_cnt;
                    end
                end
                default: begin
                    ledr  <= 18'd0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 2_500_000, clk cycles per game tick (>=2).
REQ-002 SHALL have parameter UP_TICKS, default 20, ticks a mole stays lit.
REQ-003 SHALL have parameter GAP_TICKS, default 4, ticks of dark gap between moles.
REQ-004 SHALL have parameter GAME_TICKS, default 200, game length in ticks (<=255).
REQ-005 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  single-cycle pulse; begins a game.
REQ-008 SHALL have port hit  input  1  registered hit flag from the scoring logic (SW edge AND ledr).
REQ-009 SHALL have port ledr  output  18  one-hot mole position, or all zero.
REQ-010 SHALL have port score  output  8  hits this game.
REQ-011 SHALL have port time_left  output  8  remaining game ticks.
REQ-012 SHALL have port game_over  output  1  high in OVER state.

Function
REQ-013 SHALL derive a one-cycle tick pulse from a prescaler counting 0..TICK_DIV-1, cleared on game start.
REQ-014 SHALL implement states IDLE, SPAWN, UP, GAP, OVER.
REQ-015 IDLE/OVER: start -> SPAWN next cycle; score cleared to 0, time_left loaded with GAME_TICKS, prescaler cleared.
REQ-016 SPAWN: single cycle; ledr takes the one-hot of the new position; -> UP with up-counter = UP_TICKS.
REQ-017 Position: lfsr[4:0], minus 18 when >=18; if equal to previous position, increment modulo 18.
REQ-018 UP: hit -> score+1 (saturate at 255), ledr cleared next cycle, -> GAP with gap-counter = GAP_TICKS.
REQ-019 UP: up-counter decrements on tick; reaching 0 -> ledr cleared, -> GAP, no score change.
REQ-020 UP: hit and up-timeout in the same cycle -> the hit wins (scored).
REQ-021 GAP: gap-counter decrements on tick; reaching 0 -> SPAWN.
REQ-022 hit SHALL be ignored outside UP, including the cycle after ledr clears.
REQ-023 time_left SHALL decrement on tick in SPAWN/UP/GAP; reaching 0 -> OVER, ledr=0, game_over=1, score held.
REQ-024 A hit in the same cycle as time_left reaching 0 SHALL be scored before the transition to OVER.
REQ-025 start SHALL be ignored in SPAWN/UP/GAP.
REQ-026 The LFSR (8-bit, maximal, taps x^8+x^6+x^5+x^4+1) SHALL advance every cycle regardless of state.

Reset
REQ-027 rst SHALL asynchronously force IDLE, ledr=0, score=0, time_left=0, game_over=0, prescaler=0, LFSR=8'h01.
REQ-028 rst asserted mid-game SHALL abandon the game; no partial score retained.

Configuration
REQ-029 With MOLE_SPEEDUP_EN defined, each 8th scored hit SHALL reduce the reloaded up time by 1 tick, floor 2.
REQ-030 Without MOLE_SPEEDUP_EN, the up time SHALL always be UP_TICKS and the speedup logic SHALL be absent.

Structure
REQ-031 Package mole_pkg SHALL hold the state enum, NUM_MOLES=18, and the LFSR tap constant.
REQ-032 The LFSR and position mapping SHALL live in sub-module mole_lfsr; the prescaler stays inline.

Verification (TICK_DIV=4, UP_TICKS=3, GAP_TICKS=1, GAME_TICKS=20)
REQ-033 rst then start -> SPAWN then UP, exactly one ledr bit set, time_left=20, score=0.
REQ-034 No hit -> ledr clears after 3 ticks (12 cycles), dark for 1 tick, new position different from the previous one.
REQ-035 hit pulse in UP -> score=1 and ledr=0 on the next cycle; a second hit in GAP leaves score=1.
REQ-036 hit on the same cycle as the up-timeout -> score increments; hit on the final tick -> score counted, game_over=1, ledr=0.
REQ-037 rst mid-UP -> outputs are at reset values immediately (asynchronously); start during UP is ignored.
REQ-038 With MOLE_SPEEDUP_EN and 8 hits -> next mole lit for 2 ticks; after 16 hits it is still lit for 2 ticks (floor).
